// File: rtl/btn_conditioner.sv
// -----------------------------------------------------------------------------
// btn_conditioner
//   Conditions N_BTN raw push-button pins for the counter top-level. Each pin
//   is polarity-corrected, passed through a 2-flop synchronizer and debounced.
//   For each button the block produces four outputs: a clean level, a one-cycle
//   press pulse, a one-cycle release pulse, and a toggle that flips on each
//   press.
//
//   Optional feature: define BTN_AUTOREPEAT_EN to emit extra press pulses while
//   a button is held. The first extra pulse comes REPEAT_DELAY_MS after the
//   genuine press, and further pulses follow every REPEAT_RATE_MS. Repeat
//   pulses never change toggle. When the macro is not defined, no repeat logic
//   exists.
//
// Ports
//   clk       in   main clock
//   reset     in   asynchronous reset, active-high
//   btn_raw   in   [N_BTN] raw asynchronous button pins
//   level     out  [N_BTN] debounced state, 1 = pressed
//   press     out  [N_BTN] one-cycle pulse per press (plus repeats if enabled)
//   released  out  [N_BTN] one-cycle pulse per release. "release" is a
//                          reserved word, so the port carries this name.
//   toggle    out  [N_BTN] flips on each genuine press
// -----------------------------------------------------------------------------

// Logic for one button: synchronizer, debounce counter, edge pulses, toggle
// and the optional repeat counter.
module btn_lane #(
    parameter int DB_TICKS    = 4,
    parameter bit TOGGLE_INIT = 1'b0,
    parameter int RPT_DLY     = 10,
    parameter int RPT_RATE    = 5
) (
    input  logic clk,
    input  logic reset,
    input  logic pin,        // already polarity-corrected, 1 = pressed
    output logic level,
    output logic press,
    output logic released,
    output logic toggle
);
    localparam int CW_RAW = $clog2(DB_TICKS + 1);
    localparam int CW     = (CW_RAW < 1) ? 1 : CW_RAW;

    logic [1:0]    sync;
    logic          s;
    logic [CW-1:0] cnt;
    logic          commit;
    logic          rpt_fire;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) sync <= '0;
        else       sync <= {sync[0], pin};
    end
    assign s = sync[1];

    // The window completes on the DB_TICKS-th consecutive edge with s != level.
    assign commit = (s != level) && (cnt == CW'(DB_TICKS - 1));

`ifdef BTN_AUTOREPEAT_EN
    localparam int RMAX   = (RPT_DLY > RPT_RATE) ? RPT_DLY : RPT_RATE;
    localparam int RW_RAW = $clog2(RMAX + 1);
    localparam int RW     = (RW_RAW < 1) ? 1 : RW_RAW;

    logic [RW-1:0] rpt_cnt;
    logic          rpt_first;

    // rpt_cnt holds the number of cycles elapsed since the last press pulse.
    // The first repeat waits RPT_DLY cycles. Each later repeat waits RPT_RATE.
    assign rpt_fire = level && !commit &&
                      (rpt_cnt == (rpt_first ? RW'(RPT_DLY - 1) : RW'(RPT_RATE - 1)));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rpt_cnt   <= '0;
            rpt_first <= 1'b1;
        end else if (!level || commit) begin
            rpt_cnt   <= '0;
            rpt_first <= 1'b1;
        end else if (rpt_fire) begin
            rpt_cnt   <= '0;
            rpt_first <= 1'b0;
        end else begin
            rpt_cnt   <= rpt_cnt + 1'b1;
        end
    end
`else
    logic [31:0] unused_rpt;
    assign unused_rpt = RPT_DLY ^ RPT_RATE;
    assign rpt_fire   = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt      <= '0;
            level    <= 1'b0;
            press    <= 1'b0;
            released <= 1'b0;
            toggle   <= TOGGLE_INIT;
        end else begin
            press    <= rpt_fire;
            released <= 1'b0;
            if (s == level) begin
                cnt <= '0;
            end else if (commit) begin
                cnt   <= '0;
                level <= s;
                if (s) begin
                    press  <= 1'b1;
                    toggle <= ~toggle;
                end else begin
                    released <= 1'b1;
                end
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

module btn_conditioner #(
    parameter int               N_BTN           = 2,
    parameter int               F_CLK_HZ        = 25_000_000,
    parameter int               DEBOUNCE_MS     = 20,
    parameter bit               ACTIVE_LOW      = 1'b0,
    parameter logic [N_BTN-1:0] TOGGLE_INIT     = '0,
    parameter int               REPEAT_DELAY_MS = 500,
    parameter int               REPEAT_RATE_MS  = 100
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] level,
    output logic [N_BTN-1:0] press,
    output logic [N_BTN-1:0] released,
    output logic [N_BTN-1:0] toggle
);
    localparam int TPMS     = F_CLK_HZ / 1000;
    localparam int DB_RAW   = TPMS * DEBOUNCE_MS;
    localparam int DB_TICKS = (DB_RAW < 1) ? 1 : DB_RAW;
    localparam int RD_RAW   = TPMS * REPEAT_DELAY_MS;
    localparam int RR_RAW   = TPMS * REPEAT_RATE_MS;
    localparam int RD_TICKS = (RD_RAW < 1) ? 1 : RD_RAW;
    localparam int RR_TICKS = (RR_RAW < 1) ? 1 : RR_RAW;

    // Inverting before the synchronizer keeps everything downstream active-high.
    logic [N_BTN-1:0] pin;
    assign pin = ACTIVE_LOW ? ~btn_raw : btn_raw;

    for (genvar i = 0; i < N_BTN; i++) begin : g_lane
        btn_lane #(
            .DB_TICKS   (DB_TICKS),
            .TOGGLE_INIT(TOGGLE_INIT[i]),
            .RPT_DLY    (RD_TICKS),
            .RPT_RATE   (RR_TICKS)
        ) u_lane (
            .clk     (clk),
            .reset   (reset),
            .pin     (pin[i]),
            .level   (level[i]),
            .press   (press[i]),
            .released(released[i]),
            .toggle  (toggle[i])
        );
    end
endmodule

// File: tb/tb_btn_conditioner.sv
module tb_btn_conditioner;
    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] btn_raw;
    logic [1:0] level, press, released, toggle;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    btn_conditioner #(
        .N_BTN          (2),
        .F_CLK_HZ       (1000),
        .DEBOUNCE_MS    (4),
        .ACTIVE_LOW     (1'b0),
        .TOGGLE_INIT    (2'b00),
        .REPEAT_DELAY_MS(10),
        .REPEAT_RATE_MS (5)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .btn_raw (btn_raw),
        .level   (level),
        .press   (press),
        .released(released),
        .toggle  (toggle)
    );

    // Inputs change, and outputs are sampled, 1 time unit after a rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic test_reset();
        reset   = 1'b1;
        btn_raw = 2'b00;
        idle(3);
        n_cmp += 4;
        if (level    !== 2'b00) begin n_err++; $display("FAIL reset_level got=%b exp=00", level); end
        if (press    !== 2'b00) begin n_err++; $display("FAIL reset_press got=%b exp=00", press); end
        if (released !== 2'b00) begin n_err++; $display("FAIL reset_release got=%b exp=00", released); end
        if (toggle   !== 2'b00) begin n_err++; $display("FAIL reset_toggle got=%b exp=00", toggle); end
        reset = 1'b0;
        idle(8);
        n_cmp += 2;
        if (level !== 2'b00) begin n_err++; $display("FAIL idle_level got=%b exp=00", level); end
        if (press !== 2'b00) begin n_err++; $display("FAIL idle_press got=%b exp=00", press); end
    endtask

    // Level rises on the 6th edge, counting the edge that first samples the pin.
    task automatic test_clean_press();
        logic [1:0] el, ep, et;
        btn_raw = 2'b01;
        for (int e = 1; e <= 8; e++) begin
            step();
            el = (e >= 6) ? 2'b01 : 2'b00;
            ep = (e == 6) ? 2'b01 : 2'b00;
            et = (e >= 6) ? 2'b01 : 2'b00;
            n_cmp += 4;
            if (level    !== el)    begin n_err++; $display("FAIL clean_level e=%0d got=%b exp=%b", e, level, el); end
            if (press    !== ep)    begin n_err++; $display("FAIL clean_press e=%0d got=%b exp=%b", e, press, ep); end
            if (released !== 2'b00) begin n_err++; $display("FAIL clean_release e=%0d got=%b exp=00", e, released); end
            if (toggle   !== et)    begin n_err++; $display("FAIL clean_toggle e=%0d got=%b exp=%b", e, toggle, et); end
        end
    endtask

    task automatic test_release_repress();
        logic [1:0] el, er, ep, et;
        btn_raw = 2'b00;
        for (int e = 1; e <= 8; e++) begin
            step();
            el = (e >= 6) ? 2'b00 : 2'b01;
            er = (e == 6) ? 2'b01 : 2'b00;
            n_cmp += 4;
            if (level    !== el)    begin n_err++; $display("FAIL rel_level e=%0d got=%b exp=%b", e, level, el); end
            if (released !== er)    begin n_err++; $display("FAIL rel_release e=%0d got=%b exp=%b", e, released, er); end
            if (press    !== 2'b00) begin n_err++; $display("FAIL rel_press e=%0d got=%b exp=00", e, press); end
            if (toggle   !== 2'b01) begin n_err++; $display("FAIL rel_toggle e=%0d got=%b exp=01", e, toggle); end
        end
        btn_raw = 2'b01;
        for (int e = 1; e <= 8; e++) begin
            step();
            ep = (e == 6) ? 2'b01 : 2'b00;
            et = (e >= 6) ? 2'b00 : 2'b01;
            n_cmp += 2;
            if (press  !== ep) begin n_err++; $display("FAIL repress_press e=%0d got=%b exp=%b", e, press, ep); end
            if (toggle !== et) begin n_err++; $display("FAIL repress_toggle e=%0d got=%b exp=%b", e, toggle, et); end
        end
        btn_raw = 2'b00;
        idle(8);
        n_cmp++;
        if (level !== 2'b00) begin n_err++; $display("FAIL repress_settle got=%b exp=00", level); end
    endtask

    task automatic test_simultaneous();
        logic [1:0] el, ep, er, et;
        btn_raw = 2'b11;
        for (int e = 1; e <= 8; e++) begin
            step();
            el = (e >= 6) ? 2'b11 : 2'b00;
            ep = (e == 6) ? 2'b11 : 2'b00;
            et = (e >= 6) ? 2'b11 : 2'b00;
            n_cmp += 3;
            if (level  !== el) begin n_err++; $display("FAIL sim_level e=%0d got=%b exp=%b", e, level, el); end
            if (press  !== ep) begin n_err++; $display("FAIL sim_press e=%0d got=%b exp=%b", e, press, ep); end
            if (toggle !== et) begin n_err++; $display("FAIL sim_toggle e=%0d got=%b exp=%b", e, toggle, et); end
        end
        btn_raw = 2'b00;
        for (int e = 1; e <= 8; e++) begin
            step();
            er = (e == 6) ? 2'b11 : 2'b00;
            n_cmp += 2;
            if (released !== er)    begin n_err++; $display("FAIL sim_release e=%0d got=%b exp=%b", e, released, er); end
            if (toggle   !== 2'b11) begin n_err++; $display("FAIL sim_rel_toggle e=%0d got=%b exp=11", e, toggle); end
        end
    endtask

    // Two-cycle bounces never fill the 4-edge window, so no event may appear.
    task automatic test_bounce();
        logic [1:0] el, ep, et;
        for (int k = 0; k < 8; k++) begin
            btn_raw = {1'b0, ((k / 2) % 2) == 0};
            step();
            n_cmp += 2;
            if (press !== 2'b00) begin n_err++; $display("FAIL bounce_press k=%0d got=%b exp=00", k, press); end
            if (level !== 2'b00) begin n_err++; $display("FAIL bounce_level k=%0d got=%b exp=00", k, level); end
        end
        btn_raw = 2'b01;
        for (int e = 1; e <= 8; e++) begin
            step();
            el = (e >= 6) ? 2'b01 : 2'b00;
            ep = (e == 6) ? 2'b01 : 2'b00;
            et = (e >= 6) ? 2'b10 : 2'b11;
            n_cmp += 3;
            if (level  !== el) begin n_err++; $display("FAIL bounce_hold_level e=%0d got=%b exp=%b", e, level, el); end
            if (press  !== ep) begin n_err++; $display("FAIL bounce_hold_press e=%0d got=%b exp=%b", e, press, ep); end
            if (toggle !== et) begin n_err++; $display("FAIL bounce_toggle e=%0d got=%b exp=%b", e, toggle, et); end
        end
    endtask

    task automatic test_reset_mid();
        logic [1:0] el, ep, et;
        btn_raw = 2'b00;
        idle(8);
        btn_raw = 2'b10;
        idle(4);                       // debounce count for bit 1 is at 2
        reset = 1'b1;
        #1;
        n_cmp += 4;
        if (level    !== 2'b00) begin n_err++; $display("FAIL rstmid_level got=%b exp=00", level); end
        if (press    !== 2'b00) begin n_err++; $display("FAIL rstmid_press got=%b exp=00", press); end
        if (released !== 2'b00) begin n_err++; $display("FAIL rstmid_release got=%b exp=00", released); end
        if (toggle   !== 2'b00) begin n_err++; $display("FAIL rstmid_toggle got=%b exp=00", toggle); end
        idle(2);
        n_cmp++;
        if (press !== 2'b00) begin n_err++; $display("FAIL rstmid_hold_press got=%b exp=00", press); end
        reset = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            step();
            el = (e >= 6) ? 2'b10 : 2'b00;
            ep = (e == 6) ? 2'b10 : 2'b00;
            et = (e >= 6) ? 2'b10 : 2'b00;
            n_cmp += 3;
            if (level  !== el) begin n_err++; $display("FAIL postrst_level e=%0d got=%b exp=%b", e, level, el); end
            if (press  !== ep) begin n_err++; $display("FAIL postrst_press e=%0d got=%b exp=%b", e, press, ep); end
            if (toggle !== et) begin n_err++; $display("FAIL postrst_toggle e=%0d got=%b exp=%b", e, toggle, et); end
        end
    endtask

    // Hold for 30 cycles. Cycle 0 is the genuine press cycle.
    task automatic test_hold();
        logic       rep;
        logic [1:0] ep;
        btn_raw = 2'b00;
        idle(8);
        btn_raw = 2'b01;
        idle(5);
        for (int c = 0; c < 30; c++) begin
            step();
`ifdef BTN_AUTOREPEAT_EN
            rep = (c == 0) || (c == 10) || (c == 15) || (c == 20) || (c == 25);
`else
            rep = (c == 0);
`endif
            ep = {1'b0, rep};
            n_cmp += 3;
            if (press  !== ep)    begin n_err++; $display("FAIL hold_press c=%0d got=%b exp=%b", c, press, ep); end
            if (toggle !== 2'b11) begin n_err++; $display("FAIL hold_toggle c=%0d got=%b exp=11", c, toggle); end
            if (level  !== 2'b01) begin n_err++; $display("FAIL hold_level c=%0d got=%b exp=01", c, level); end
        end
        btn_raw = 2'b00;
        idle(8);
        n_cmp++;
        if (level !== 2'b00) begin n_err++; $display("FAIL hold_release_level got=%b exp=00", level); end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_release_repress();
        test_simultaneous();
        test_bounce();
        test_reset_mid();
        test_hold();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
